fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the one-cycle MIPS core, directly upstream of the controller. Holds the program counter, fetches one word per instruction from instruction memory over a request/valid handshake, and presents the held instruction (opcode/funct slices) to the controller. It computes the next PC from the controller's branch/jump decisions and advances only when the core signals retirement.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- o_imem_req  out  1  fetch request, held until i_imem_rvalid
- o_imem_addr  out  32  fetch address, equals o_pc
- i_imem_rvalid  in  1  read data valid this cycle; may arrive the same cycle as req
- i_imem_rdata  in  32  instruction word
- o_instr  out  32  held instruction
- o_opcode  out  6  o_instr[31:26], to controller i_opcode
- o_funct  out  6  o_instr[5:0], to controller i_funct
- o_instr_valid  out  1  o_instr is current and executing
- i_branch  in  1  controller branch
- i_zero  in  1  ALU zero flag
- i_jmp  in  1  controller jump
- i_retire  in  1  core completes current instruction this cycle
- o_pc  out  32  address of held/fetching instruction
- o_pc_plus4  out  32  o_pc + 4
- o_retired_cnt  out  32  retired instruction count

## Operation
- States: IDLE, FETCH, EXEC. Reset -> IDLE; IDLE -> FETCH unconditionally next cycle.
- FETCH: o_imem_req=1, o_imem_addr=o_pc. On i_imem_rvalid: o_instr <= i_imem_rdata, -> EXEC.
- EXEC: o_instr_valid=1, o_imem_req=0. On i_retire: o_pc <= next_pc, o_retired_cnt += 1, -> FETCH.
- next_pc priority: i_jmp -> {o_pc_plus4[31:28], o_instr[25:0], 2'b00}; else i_branch & i_zero -> o_pc_plus4 + (sign-extended o_instr[15:0] << 2); else o_pc_plus4. Branch/jump inputs sampled only on the retire edge.
- All PC arithmetic 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. o_retired_cnt wraps to 0 after 32'hFFFF_FFFF.
- i_imem_rvalid ignored outside FETCH; i_retire ignored outside EXEC.
- i_jmp and i_branch both high: jump wins.

## Timing
- Reset values: o_pc=RESET_PC, o_instr=0, o_instr_valid=0, o_imem_req=0, o_retired_cnt=0, state IDLE.
- o_imem_req, o_instr_valid are registered state decodes; no combinational path from any input to any output except through registers (o_opcode/o_funct/o_imem_addr/o_pc_plus4 derive from registers only).
- Fetch latency: rvalid in cycle N -> o_instr_valid high in N+1.
- Minimum throughput: IDLE 1 cycle after reset, then 2 cycles per instruction (1 FETCH with same-cycle rvalid, 1 EXEC with i_retire).
- Retire in cycle N -> new o_pc and o_imem_req=1 in N+1.
- i_rst in any state wins over all other inputs that edge; an outstanding fetch is abandoned and a late rvalid arriving in IDLE is dropped.

## Structure
- Shared package fetch_pkg: state enum (IDLE/FETCH/EXEC), field position constants (OPCODE_MSB/LSB, FUNCT_MSB/LSB, IMM16, JADDR26), default RESET_PC.
- One combinational sub-module npc_logic: inputs pc_plus4, instr, branch, zero, jmp; output next_pc.

## Test plan
- Reset with RESET_PC=32'h0040_0000 -> all outputs at reset values; 1 cycle later o_imem_req=1, o_imem_addr=32'h0040_0000.
- Sequential: memory returns 32'h0000_0020 (add) same cycle, i_retire next cycle, no branch/jump -> o_pc=32'h0040_0004, o_retired_cnt=1, o_funct=6'h20.
- Taken branch: instr 32'h1000_FFFF at pc 32'h0040_0010, i_branch=1, i_zero=1 -> next o_pc=32'h0040_0010; with i_zero=0 -> 32'h0040_0014.
- Jump: instr 32'h0810_0040 at pc 32'h0040_0000, i_jmp=1 and i_branch=1 -> o_pc=32'h0040_0100.
- Memory stall: rvalid delayed 3 cycles -> o_imem_req held 4 cycles with stable address, o_instr_valid low throughout; spurious i_retire during FETCH ignored.
- Reset mid-fetch, rvalid asserted one cycle after reset edge -> dropped, o_instr_valid stays 0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and instruction field positions for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM16_MSB  = 15;
  localparam int JADDR_MSB  = 25;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch displacement: sign-extended 16-bit word offset as a byte offset.
  function automatic logic [31:0] branch_offset(input logic [IMM16_MSB:0] imm);
    return {{14{imm[IMM16_MSB]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_npc_logic.sv
// Next-PC selection for the retiring instruction: jump beats taken branch beats sequential.
module npc_logic
  import fetch_pkg::*;
(
  input  logic [31:0]        i_pc_plus4,
  input  logic [JADDR_MSB:0] i_instr,
  input  logic               i_branch,
  input  logic               i_zero,
  input  logic               i_jmp,
  output logic [31:0]        o_next_pc
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;

  assign w_jump_target   = {i_pc_plus4[31:28], i_instr[JADDR_MSB:0], 2'b00};
  assign w_branch_target = i_pc_plus4 + branch_offset(i_instr[IMM16_MSB:0]);

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_jmp) begin
      o_next_pc = w_jump_target;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC, fetches one word per instruction, advances on retire.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opcode,
  output logic [5:0]  o_funct,
  output logic        o_instr_valid,
  input  logic        i_branch,
  input  logic        i_zero,
  input  logic        i_jmp,
  input  logic        i_retire,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_retired_cnt,
  output logic [1:0]  o_state
);

  // Handshake: o_imem_req stays high for the whole FETCH state; the word is
  // accepted on any edge where req and i_imem_rvalid are both high. rvalid
  // outside FETCH and i_retire outside EXEC have no effect.

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired_cnt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_accept;
  logic        w_retire;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_accept   = (r_state == ST_FETCH) && i_imem_rvalid;
  assign w_retire   = (r_state == ST_EXEC) && i_retire;

  npc_logic u_npc (
    .i_pc_plus4 (w_pc_plus4),
    .i_instr    (r_instr[JADDR_MSB:0]),
    .i_branch   (i_branch),
    .i_zero     (i_zero),
    .i_jmp      (i_jmp),
    .o_next_pc  (w_next_pc)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = ST_FETCH;
      ST_FETCH: if (i_imem_rvalid) w_state_next = ST_EXEC;
      ST_EXEC:  if (i_retire) w_state_next = ST_FETCH;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_retired_cnt <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_instr <= i_imem_rdata;
      end
      if (w_retire) begin
        r_pc          <= w_next_pc;
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
    end
  end

  assign o_imem_req    = (r_state == ST_FETCH);
  assign o_instr_valid = (r_state == ST_EXEC);
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_instr       = r_instr;
  assign o_opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign o_funct       = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign o_retired_cnt = r_retired_cnt;
  assign o_state       = r_state;

endmodule
